// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage between program counter and execute stage
//
// Purpose: takes one program address per four-phase req/ack handshake, reads the
// instruction word from a synchronous program ROM, buffers it as opcode/operand for
// the execute stage (second four-phase handshake), and decodes JMP locally to drive
// the program counter's load path.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_prev / ack_prev     address handshake with the program counter (req async)
//   address_in              program address, stable while req_prev is high
//   rom_en / rom_addr       ROM read strobe and address
//   rom_data                ROM word, valid the cycle after rom_en
//   req_next / ack_next     instruction handshake with the execute stage (ack async)
//   opcode_out/operand_out  buffered instruction fields
//   pc_write / pc_address   jump load request and target for the program counter
module instruction_fetch #(
    parameter int ADDR_WIDTH    = 8,
    parameter int OPERAND_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_prev,
    output logic                       ack_prev,
    input  logic [ADDR_WIDTH-1:0]      address_in,
    output logic                       rom_en,
    output logic [ADDR_WIDTH-1:0]      rom_addr,
    input  logic [4+OPERAND_WIDTH-1:0] rom_data,
    output logic                       req_next,
    input  logic                       ack_next,
    output logic [3:0]                 opcode_out,
    output logic [OPERAND_WIDTH-1:0]   operand_out,
    output logic                       pc_write,
    output logic [ADDR_WIDTH-1:0]      pc_address
);

    localparam int          WORD_WIDTH = 4 + OPERAND_WIDTH;
    localparam logic [3:0]  OP_JMP     = 4'hC;

    typedef enum logic [1:0] {F_IDLE, F_READ, F_ACK, F_RTZ} fetch_state_t;
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_RTZ}         out_state_t;

    fetch_state_t f_state;
    out_state_t   o_state;
    logic         buf_full;

    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   req_s;
    logic                   ack_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync <= '0;
            ack_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_prev};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_next};
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];
    assign ack_s = ack_sync[SYNC_STAGES-1];

    logic set_buf;
    logic clr_buf;
    assign set_buf = (f_state == F_ACK);
    assign clr_buf = (o_state == O_REQ) && ack_s;

    // Both FSMs share one block because buf_full is set by the fetch side and
    // cleared by the output side.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_state     <= F_IDLE;
            o_state     <= O_IDLE;
            buf_full    <= 1'b0;
            ack_prev    <= 1'b0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            req_next    <= 1'b0;
            opcode_out  <= '0;
            operand_out <= '0;
            pc_write    <= 1'b0;
            pc_address  <= '0;
        end else begin
            case (f_state)
                F_IDLE: begin
                    if (req_s && !buf_full) begin
                        rom_addr <= address_in;
                        rom_en   <= 1'b1;
                        f_state  <= F_READ;
                    end
                end
                F_READ: begin
                    rom_en  <= 1'b0;
                    f_state <= F_ACK;
                end
                F_ACK: begin
                    opcode_out  <= rom_data[WORD_WIDTH-1 -: 4];
                    operand_out <= rom_data[OPERAND_WIDTH-1:0];
                    ack_prev    <= 1'b1;
                    // JMP result holds until the next capture so the program
                    // counter sees it before its following request.
                    if (rom_data[WORD_WIDTH-1 -: 4] == OP_JMP) begin
                        pc_write   <= 1'b1;
                        pc_address <= ADDR_WIDTH'(rom_data[OPERAND_WIDTH-1:0]);
                    end else begin
                        pc_write   <= 1'b0;
                    end
                    f_state <= F_RTZ;
                end
                F_RTZ: begin
                    if (!req_s) begin
                        ack_prev <= 1'b0;
                        f_state  <= F_IDLE;
                    end
                end
                default: f_state <= F_IDLE;
            endcase

            case (o_state)
                O_IDLE: begin
                    // Requiring ack_s low also discards an acknowledge left
                    // high across a reset until it has been seen low.
                    if (buf_full && !ack_s) begin
                        req_next <= 1'b1;
                        o_state  <= O_REQ;
                    end
                end
                O_REQ: begin
                    if (ack_s) begin
                        req_next <= 1'b0;
                        o_state  <= O_RTZ;
                    end
                end
                O_RTZ: begin
                    if (!ack_s) begin
                        o_state <= O_IDLE;
                    end
                end
                default: o_state <= O_IDLE;
            endcase

            if (set_buf) begin
                buf_full <= 1'b1;
            end else if (clr_buf) begin
                buf_full <= 1'b0;
            end
        end
    end

    // F_IDLE only leaves with buf_full low, so a capture can never meet a release.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(set_buf && clr_buf));
        end
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Stage directly downstream of the program counter.
- Accepts each program address over a four-phase req/ack handshake and reads one instruction word from an external synchronous program ROM.
- Splits the word into opcode and operand and hands it to the execute stage over a second four-phase handshake.
- Decodes JMP locally and drives the program counter's write/address_in load path, so the next increment is replaced by the jump target.

Parameters:
- ADDR_WIDTH, 8, program address width; matches the program counter.
- OPERAND_WIDTH, 4, operand (I/O address) field width; instruction word = 4 + OPERAND_WIDTH bits, opcode in the MSBs.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous handshake input (req_prev, ack_next); minimum 2.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_prev  in  1  address request from program counter (asynchronous)
- ack_prev  out  1  address acknowledge to program counter
- address_in  in  ADDR_WIDTH  address from program counter; stable while req_prev high
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_data  in  4+OPERAND_WIDTH  ROM word; valid on the cycle after rom_en
- req_next  out  1  instruction request to execute stage
- ack_next  in  1  acknowledge from execute stage (asynchronous)
- opcode_out  out  4  buffered opcode
- operand_out  out  OPERAND_WIDTH  buffered operand
- pc_write  out  1  load request to program counter
- pc_address  out  ADDR_WIDTH  jump target to program counter

Behaviour:
- req_s and ack_s are req_prev and ack_next after SYNC_STAGES flops. Synchronizers clear on reset.
- Reset values: ack_prev=0, rom_en=0, rom_addr=0, req_next=0, opcode_out=0, operand_out=0, pc_write=0, pc_address=0, buf_full=0. Both FSMs reset to their first state.
- Fetch FSM states: F_IDLE, F_READ, F_ACK, F_RTZ.
  - F_IDLE: if req_s=1 and buf_full=0, go to F_READ. On the same edge, register rom_addr<=address_in and rom_en<=1. If buf_full=1, stall; ack_prev stays 0.
  - F_READ: rom_en<=0 and go to F_ACK.
  - F_ACK: capture rom_data into the buffer: opcode_out<=rom_data[MSB-:4], operand_out<=low OPERAND_WIDTH bits, buf_full<=1. Set ack_prev<=1 and go to F_RTZ.
  - F_RTZ: wait for req_s=0, then ack_prev<=0 and go to F_IDLE.
- Latency: ack_prev rises 3 cycles after req_s rises (SYNC_STAGES+3 clk after req_prev, worst case +1 for metastability window).
- JMP decode (opcode 4'hC), evaluated in F_ACK:
  - On JMP: pc_write<=1; pc_address<=operand zero-extended or truncated to ADDR_WIDTH.
  - Any other opcode: pc_write<=0.
  - Both outputs hold until the next F_ACK. They must therefore be stable before the program counter's following req_prev edge. The JMP word is still forwarded downstream.
- Output FSM states: O_IDLE, O_REQ, O_RTZ.
  - O_IDLE: when buf_full=1, req_next<=1 and go to O_REQ.
  - O_REQ: on ack_s=1, req_next<=0 and buf_full<=0, go to O_RTZ.
  - O_RTZ: wait for ack_s=0, then go to O_IDLE.
- opcode_out and operand_out are stable from req_next rise until the next capture.
- Single-entry buffer: one fetch may complete while the output side is in O_RTZ. No fetch completes while buf_full=1.
- Simultaneous set and clear of buf_full (F_ACK and O_REQ in the same cycle) cannot occur, because F_IDLE requires buf_full=0. Assert this in simulation.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight handshakes are abandoned.
  - A req_prev still high after reset is treated as a new request.
  - An ack_next still high after reset is ignored until it has been seen low.
- Behaviour is independent of address value; no wrap handling beyond ADDR_WIDTH truncation.

Test Plan:
- Basic fetch: ROM[0x05]=8'h3A, PC offers 0x05 -> rom_addr=0x05 with rom_en one cycle; ack_prev rises SYNC_STAGES+3 clk after req_prev; then req_next=1 with opcode_out=4'h3, operand_out=4'hA.
- JMP: ROM[0x10]=8'hC7 -> pc_write=1, pc_address=0x07 after F_ACK, held through the next fetch; next fetch of non-JMP 8'h10 -> pc_write=0.
- Back-pressure: ack_next held low, PC issues two addresses -> first word presented; second req_prev gets no ack_prev; releasing ack_next -> second fetch completes with correct data.
- Four-phase order: ack_prev falls only after req_prev falls; req_next falls only after ack_next rises; no new req_next until ack_next observed low.
- Reset mid-handshake: assert reset for 1 clk while ack_prev=1 and req_next=1 -> all outputs 0 next edge; stale high ack_next ignored until it drops low; a high req_prev restarts a fetch.
- Synchronizer: req_prev pulse toggling on non-clk-aligned times at SYNC_STAGES=3 -> ack latency is 6 or 7 clk; no X on outputs.
